// File: rtl/rtlbus_dist.sv
// ---------------------------------------------------------------------------
// rtlbus_dist
//   One-hot bus distributor. A single O-bit word stream (valid/ready) is
//   steered into one of N output lanes. Each lane owns a one-entry holding
//   register with its own valid/ready handshake. Lane data is packed flat so
//   it can feed the N*O-bit input of the one-hot bus selector directly.
//
// Ports
//   clk      : system clock, all logic on the rising edge
//   rst_n    : synchronous reset, active-low
//   in_vld   : input word valid
//   in_rdy   : input can accept this cycle (combinational)
//   in_en    : one-hot lane select, qualified by in_vld
//   in_dat   : input word
//   out_vld  : per-lane holding register full
//   out_rdy  : per-lane consumer ready
//   out_dat  : packed lane data, lane i at [i*O+O-1 : i*O]
//   err      : one-cycle pulse per word dropped for an illegal in_en
//   err_cnt  : saturating count of dropped words
//
// Configuration
//   RTLBUS_DIST_RR_EN : when defined, in_en is ignored and lanes are filled
//                       round-robin from an internal pointer; err and
//                       err_cnt then stay at 0.
// ---------------------------------------------------------------------------
module rtlbus_dist #(
  parameter int N = 6,
  parameter int O = 8,
  parameter int I = N * O
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [N-1:0] in_en,
  input  logic [O-1:0] in_dat,
  output logic [N-1:0] out_vld,
  input  logic [N-1:0] out_rdy,
  output logic [I-1:0] out_dat,
  output logic         err,
  output logic [7:0]   err_cnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  outVld_q, outVld_d;
  logic [I-1:0]  outDat_q, outDat_d;
  logic          err_q, err_d;
  logic [7:0]    errCnt_q, errCnt_d;

  logic [PW-1:0] selIdx;
  logic          selLegal;
  logic          accept;
  logic [N-1:0]  loadVec;

`ifdef RTLBUS_DIST_RR_EN
  // Round-robin target: the pointer walks 0..N-1 and wraps explicitly so a
  // non-power-of-two lane count never lands on a missing lane.
  logic [PW-1:0] ptr_q, ptr_d;
  logic          unusedEn;

  assign unusedEn = ^in_en;
  assign selIdx   = ptr_q;
  assign selLegal = 1'b1;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Decode in_en: count the set bits and remember the set position. Only a
  // count of exactly one is a legal select; anything else gets dropped.
  logic [5:0] selCnt;

  always_comb begin
    selCnt = '0;
    selIdx = '0;
    for (int k = 0; k < N; k++) begin
      if (in_en[k]) begin
        selCnt = selCnt + 6'd1;
        selIdx = PW'(k);
      end
    end
  end

  assign selLegal = (selCnt == 6'd1);
`endif

  // Accept rules: an illegal select is always swallowed, a legal one needs
  // the target lane empty or draining this edge. Nothing is accepted while
  // reset is held.
  assign in_rdy  = rst_n & (~selLegal | ~outVld_q[selIdx] | out_rdy[selIdx]);
  assign accept  = in_vld & in_rdy;
  assign loadVec = (accept && selLegal) ? (N'(1) << selIdx) : '0;

  // Lane and error next state. A drain clears valid, but a load at the same
  // edge wins so a lane can stream one word per cycle. Lane data is only
  // ever overwritten by a load, so it holds its last value after a drain.
  always_comb begin
    outVld_d = (outVld_q & ~out_rdy) | loadVec;
    outDat_d = outDat_q;
    for (int k = 0; k < N; k++) begin
      if (loadVec[k]) begin
        outDat_d[k*O +: O] = in_dat;
      end
    end
    err_d    = accept & ~selLegal;
    errCnt_d = errCnt_q;
    if (err_d && (errCnt_q != 8'hFF)) begin
      errCnt_d = errCnt_q + 8'd1;
    end
  end

  // State registers; reset discards any held words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outVld_q <= '0;
      outDat_q <= '0;
      err_q    <= 1'b0;
      errCnt_q <= '0;
    end else begin
      outVld_q <= outVld_d;
      outDat_q <= outDat_d;
      err_q    <= err_d;
      errCnt_q <= errCnt_d;
    end
  end

  assign out_vld = outVld_q;
  assign out_dat = outDat_q;
  assign err     = err_q;
  assign err_cnt = errCnt_q;

endmodule

// File: tb/tb_rtlbus_dist.sv
// ---------------------------------------------------------------------------
// tb_rtlbus_dist
//   Self-checking bench for rtlbus_dist (N=6, O=8). A lane-level model is
//   compared against the DUT on every falling edge, and directed sequences
//   add literal expectations. Define RTLBUS_DIST_RR_EN to exercise the
//   round-robin build.
// ---------------------------------------------------------------------------
module tb_rtlbus_dist;

  localparam int N = 6;
  localparam int O = 8;
  localparam int I = N * O;

  logic         clk;
  logic         rst_n;
  logic         in_vld;
  logic         in_rdy;
  logic [N-1:0] in_en;
  logic [O-1:0] in_dat;
  logic [N-1:0] out_vld;
  logic [N-1:0] out_rdy;
  logic [I-1:0] out_dat;
  logic         err;
  logic [7:0]   err_cnt;

  int nCompared   = 0;
  int nMismatched = 0;

  rtlbus_dist #(.N(N), .O(O)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_en   (in_en),
    .in_dat  (in_dat),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_dat (out_dat),
    .err     (err),
    .err_cnt (err_cnt)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane-level reference: each lane is a "full" flag plus a byte, the
  // dropped-word count is a plain integer clamped at 255.
  bit       mdlInit = 0;
  bit       mdlFull [N];
  bit [7:0] mdlByte [N];
  bit       mdlErr;
  int       mdlErrCount;
  int       mdlPtr;

  function automatic int mdlTarget();
`ifdef RTLBUS_DIST_RR_EN
    return mdlPtr;
`else
    if ($countones(in_en) != 1) return -1;
    for (int k = 0; k < N; k++) if (in_en[k]) return k;
    return -1;
`endif
  endfunction

  function automatic bit mdlReady();
    int t;
    if (!rst_n) return 0;
    t = mdlTarget();
    if (t < 0) return 1;
    return !mdlFull[t] || out_rdy[t];
  endfunction

  always @(posedge clk) begin
    int  t;
    bit  acc;
    if (!rst_n) begin
      mdlInit = 1;
      for (int k = 0; k < N; k++) begin
        mdlFull[k] = 0;
        mdlByte[k] = 8'h00;
      end
      mdlErr      = 0;
      mdlErrCount = 0;
      mdlPtr      = 0;
    end else if (mdlInit) begin
      acc = in_vld && mdlReady();
      t   = mdlTarget();
      for (int k = 0; k < N; k++) if (out_rdy[k]) mdlFull[k] = 0;
      mdlErr = 0;
      if (acc) begin
        if (t >= 0) begin
          mdlFull[t] = 1;
          mdlByte[t] = in_dat;
          mdlPtr     = (mdlPtr + 1) % N;
        end else begin
          mdlErr = 1;
          if (mdlErrCount < 255) mdlErrCount++;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, once it has seen reset.
  always @(negedge clk) begin
    logic [N-1:0] eVld;
    logic [I-1:0] eDat;
    if (mdlInit) begin
      for (int k = 0; k < N; k++) begin
        eVld[k]          = mdlFull[k];
        eDat[k*O +: O]   = mdlByte[k];
      end
      checkOutput("mdl.in_rdy",  64'(in_rdy),  64'(mdlReady()));
      checkOutput("mdl.out_vld", 64'(out_vld), 64'(eVld));
      checkOutput("mdl.out_dat", 64'(out_dat), 64'(eDat));
      checkOutput("mdl.err",     64'(err),     64'(mdlErr));
      checkOutput("mdl.err_cnt", 64'(err_cnt), 64'(mdlErrCount));
    end
  end

  // Drive one cycle of inputs, advance past the next rising edge.
  task automatic applyStimulus(input logic vld, input logic [N-1:0] en,
                               input logic [O-1:0] dat, input logic [N-1:0] rdy);
    in_vld  = vld;
    in_en   = en;
    in_dat  = dat;
    out_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 8'h00, '0);
    applyStimulus(1'b0, '0, 8'h00, '0);
    checkOutput("rst.in_rdy", 64'(in_rdy), 64'd0);
    rst_n = 1'b1;
    checkOutput("rst.out_vld", 64'(out_vld), 64'd0);
    checkOutput("rst.out_dat", 64'(out_dat), 64'd0);
    checkOutput("rst.err_cnt", 64'(err_cnt), 64'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_en   = '0;
    in_dat  = '0;
    out_rdy = '0;
    doReset();

`ifdef RTLBUS_DIST_RR_EN
    // Seven words with every lane ready: 0,1,2,3,4,5,0
    for (int j = 0; j < 7; j++) begin
      applyStimulus(1'b1, '0, 8'(8'h10 + j), 6'b111111);
      checkOutput("rr.vld", 64'(out_vld), 64'(6'b000001 << (j % N)));
      checkOutput("rr.dat", 64'(out_dat[(j % N)*O +: O]), 64'(8'h10 + j));
    end
    checkOutput("rr.lane0_last", 64'(out_dat[7:0]), 64'h16);
    // Six more words with lane 1 stalled: pointer returns to 1, lane 1 full
    for (int j = 0; j < 6; j++) begin
      applyStimulus(1'b1, '0, 8'(8'h20 + j), 6'b111101);
    end
    #1;
    checkOutput("rr.stall_rdy",  64'(in_rdy), 64'd0);
    checkOutput("rr.lane1_vld",  64'(out_vld[1]), 64'd1);
    checkOutput("rr.lane1_dat",  64'(out_dat[15:8]), 64'h20);
    checkOutput("rr.err_cnt",    64'(err_cnt), 64'd0);
    out_rdy = 6'b111111;
    #1;
    checkOutput("rr.unstall_rdy", 64'(in_rdy), 64'd1);
    applyStimulus(1'b0, '0, 8'h00, 6'b111111);
`else
    // Basic load into lane 2
    in_vld = 1'b1; in_en = 6'b000100; in_dat = 8'hA5; out_rdy = '0;
    #1;
    checkOutput("load.rdy_pre", 64'(in_rdy), 64'd1);
    applyStimulus(1'b1, 6'b000100, 8'hA5, 6'b000000);
    checkOutput("load.vld",  64'(out_vld), 64'(6'b000100));
    checkOutput("load.dat",  64'(out_dat[23:16]), 64'hA5);
    checkOutput("load.full", 64'(in_rdy), 64'd0);
    // Drain lane 2; data is held
    applyStimulus(1'b0, 6'b000100, 8'h00, 6'b000100);
    checkOutput("drain.vld", 64'(out_vld), 64'd0);
    checkOutput("drain.dat", 64'(out_dat[23:16]), 64'hA5);

    // Back-to-back on lane 0
    for (int j = 1; j <= 3; j++) begin
      applyStimulus(1'b1, 6'b000001, 8'(j), 6'b000001);
      checkOutput("b2b.dat", 64'(out_dat[7:0]), 64'(j));
      checkOutput("b2b.vld", 64'(out_vld[0]), 64'd1);
      checkOutput("b2b.rdy", 64'(in_rdy), 64'd1);
    end
    applyStimulus(1'b0, '0, 8'h00, 6'b000001);
    checkOutput("b2b.empty", 64'(out_vld), 64'd0);

    // Illegal selects: zero and two-hot
    in_vld = 1'b1; in_en = 6'b000000; in_dat = 8'hFF; out_rdy = '0;
    #1;
    checkOutput("ill.rdy", 64'(in_rdy), 64'd1);
    applyStimulus(1'b1, 6'b000000, 8'hFF, 6'b000000);
    checkOutput("ill.err1", 64'(err), 64'd1);
    checkOutput("ill.cnt1", 64'(err_cnt), 64'd1);
    applyStimulus(1'b1, 6'b010010, 8'hEE, 6'b000000);
    checkOutput("ill.err2", 64'(err), 64'd1);
    checkOutput("ill.cnt2", 64'(err_cnt), 64'd2);
    checkOutput("ill.vld",  64'(out_vld), 64'd0);
    applyStimulus(1'b0, '0, 8'h00, 6'b000000);
    checkOutput("ill.err0", 64'(err), 64'd0);
    checkOutput("ill.cnt",  64'(err_cnt), 64'd2);

    // Backpressure independence: lane 5 full and stalled, lane 1 written
    applyStimulus(1'b1, 6'b100000, 8'h5A, 6'b000000);
    in_vld = 1'b1; in_en = 6'b000010; in_dat = 8'h11;
    #1;
    checkOutput("bp.rdy1", 64'(in_rdy), 64'd1);
    applyStimulus(1'b1, 6'b000010, 8'h11, 6'b000000);
    checkOutput("bp.vld",   64'(out_vld), 64'(6'b100010));
    checkOutput("bp.dat5",  64'(out_dat[47:40]), 64'h5A);
    checkOutput("bp.dat1",  64'(out_dat[15:8]), 64'h11);
    applyStimulus(1'b0, '0, 8'h00, 6'b100000);
    checkOutput("bp.drain", 64'(out_vld), 64'(6'b000010));
    checkOutput("bp.hold5", 64'(out_dat[47:40]), 64'h5A);

    // Reset mid-operation with lanes 0 and 3 full
    applyStimulus(1'b1, 6'b000001, 8'hC0, 6'b000000);
    applyStimulus(1'b1, 6'b001000, 8'hC3, 6'b000000);
    checkOutput("mid.vld", 64'(out_vld), 64'(6'b001011));
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 8'h00, 6'b000000);
    rst_n = 1'b1;
    checkOutput("mid.rst_vld", 64'(out_vld), 64'd0);
    checkOutput("mid.rst_dat", 64'(out_dat), 64'd0);
    checkOutput("mid.rst_cnt", 64'(err_cnt), 64'd0);

    // 300 illegal words saturate the counter
    for (int j = 0; j < 300; j++) begin
      applyStimulus(1'b1, 6'b000011, 8'(j), 6'b000000);
    end
    checkOutput("sat.cnt", 64'(err_cnt), 64'd255);
    checkOutput("sat.err", 64'(err), 64'd1);
    applyStimulus(1'b0, '0, 8'h00, 6'b000000);
    checkOutput("sat.hold", 64'(err_cnt), 64'd255);
    checkOutput("sat.err0", 64'(err), 64'd0);
    checkOutput("sat.vld",  64'(out_vld), 64'd0);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
